// File: rtl/regfile_dump_reader.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_dump_reader
//  Description : Sequential reader on the register-file debug port. A start
//                pulse walks debug_addr from first_addr to last_addr, wrapping
//                modulo 2**ADDR_W. Each register is snapshotted and offered
//                as an (addr, data) valid/ready beat. The regfile is never
//                written.
//  Ports       : clk, rst_n          - clock, async active-low reset
//                start               - begin a dump (sampled in IDLE only)
//                first_addr/last_addr- dump range (sampled with start)
//                debug_addr          - registered address to regfile debug port
//                debug_data_reg      - combinational regfile read data
//                out_valid/out_ready - output stream handshake
//                out_addr/out_data   - captured register address / value
//                busy                - high in any state except IDLE
//                done                - one-cycle pulse after the last handshake
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_dump_reader #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic [ADDR_W-1:0] debug_addr,
    input  logic [DATA_W-1:0] debug_data_reg,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] c_addr_one = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            r_state;
    logic [ADDR_W-1:0] r_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_last     <= '0;
            debug_addr <= '0;
            out_addr   <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            // done is a single-cycle pulse; only the final handshake raises it
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        debug_addr <= first_addr;
                        r_last     <= last_addr;
                        r_state    <= S_FETCH;
                        busy       <= 1'b1;
                    end
                end
                S_FETCH: begin
                    // Snapshot: later regfile writes cannot disturb out_data.
                    // r0 has no storage, so its read data is ignored.
                    out_addr  <= debug_addr;
                    out_data  <= (debug_addr == '0) ? '0 : debug_data_reg;
                    out_valid <= 1'b1;
                    r_state   <= S_HOLD;
                end
                S_HOLD: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        if (out_addr == r_last) begin
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            // natural wrap from all-ones back to 0
                            debug_addr <= debug_addr + c_addr_one;
                            r_state    <= S_FETCH;
                        end
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
